// File: rtl/proc_control_fsm.sv
// Multi-cycle control FSM for the 16-bit bus processor: latches an instruction on run and
// sequences bus select, register writes and ALU op over T1..T3. Optional: CTRL_MUL_STALL_EN.
module proc_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [8:0] din,
  input  logic       alu_ready,
  output logic [8:0] ir,
  output logic [3:0] bus_mux_sel,
  output logic [7:0] reg_bank_write,
  output logic       reg_a_write,
  output logic       reg_g_write,
  output logic       reg_h_write,
  output logic [2:0] alu_op,
  output logic       busy,
  output logic       done,
  output logic [3:0] tick
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    T1   = 4'b0010,
    T2   = 4'b0100,
    T3   = 4'b1000
  } state_t;

  typedef enum logic [2:0] {
    OP_DISP = 3'b000,
    OP_ADD  = 3'b001,
    OP_ADDI = 3'b010,
    OP_SUB  = 3'b011,
    OP_MUL  = 3'b100,
    OP_SRL  = 3'b101,
    OP_SLL  = 3'b110,
    OP_MOVI = 3'b111
  } opcode_t;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] bank;
    logic       a;
    logic       g;
    logic       h;
    logic [2:0] alu;
    logic       done;
    logic       busy;
    logic [3:0] tick;
  } ctrl_t;

  state_t     state, state_nxt;
  logic [8:0] ir_nxt;
  ctrl_t      ctrl_q;
  logic       mul_wait;

  // Moore decode; evaluated on the next state/ir so the outputs can be registered
  function automatic ctrl_t decode(input state_t st, input logic [8:0] instr);
    ctrl_t   c;
    opcode_t op;
    c      = '0;
    op     = opcode_t'(instr[8:6]);
    c.tick = st;
    c.busy = (st != IDLE);
    case (st)
      T1: begin
        case (op)
          OP_DISP: begin c.sel = {1'b0, instr[5:3]}; c.h = 1'b1; c.done = 1'b1; end
          OP_MOVI: begin c.sel = 4'd8; c.bank = 8'b1 << instr[5:3]; c.done = 1'b1; end
          default: begin c.sel = {1'b0, instr[5:3]}; c.a = 1'b1; end
        endcase
      end
      T2: begin
        c.sel = (op == OP_ADDI) ? 4'd8 : {1'b0, instr[2:0]};
        c.g   = 1'b1;
        case (op)
          OP_SUB:  c.alu = 3'b001;
          OP_MUL:  c.alu = 3'b010;
          OP_SRL:  c.alu = 3'b011;
          OP_SLL:  c.alu = 3'b100;
          default: c.alu = 3'b000;
        endcase
      end
      T3: begin
        c.sel  = 4'd9;
        c.bank = 8'b1 << instr[5:3];
        c.done = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

`ifdef CTRL_MUL_STALL_EN
  assign mul_wait = (state == T2) && (opcode_t'(ir[8:6]) == OP_MUL);
`else
  logic unused_alu_ready;
  assign unused_alu_ready = alu_ready;
  assign mul_wait         = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    case (state)
      IDLE: if (run) begin state_nxt = T1; ir_nxt = din; end
      T1:   state_nxt = (opcode_t'(ir[8:6]) == OP_DISP || opcode_t'(ir[8:6]) == OP_MOVI) ? IDLE : T2;
      T2:   state_nxt = (mul_wait && !alu_ready) ? T2 : T3;
      T3:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ir     <= '0;
      ctrl_q <= decode(IDLE, '0);
    end else begin
      state  <= state_nxt;
      ir     <= ir_nxt;
      ctrl_q <= decode(state_nxt, ir_nxt);
    end
  end

  assign bus_mux_sel    = ctrl_q.sel;
  assign reg_bank_write = ctrl_q.bank;
  assign reg_a_write    = ctrl_q.a;
  // While a MUL waits in T2, G is written only in the cycle the ALU reports ready
  assign reg_g_write    = ctrl_q.g & (~mul_wait | alu_ready);
  assign reg_h_write    = ctrl_q.h;
  assign alu_op         = ctrl_q.alu;
  assign done           = ctrl_q.done;
  assign busy           = ctrl_q.busy;
  assign tick           = ctrl_q.tick;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed-vector bench for proc_control_fsm; define CTRL_MUL_STALL_EN to cover the MUL stall.
module tb_proc_control_fsm;

  logic       clk = 1'b0;
  logic       rst, run, alu_ready;
  logic [8:0] din, ir;
  logic [3:0] bus_mux_sel, tick;
  logic [7:0] reg_bank_write;
  logic       reg_a_write, reg_g_write, reg_h_write, busy, done;
  logic [2:0] alu_op;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  localparam logic [3:0] S_IDLE = 4'b0001, S_T1 = 4'b0010, S_T2 = 4'b0100, S_T3 = 4'b1000;

  proc_control_fsm dut (
    .clk(clk), .rst(rst), .run(run), .din(din), .alu_ready(alu_ready), .ir(ir),
    .bus_mux_sel(bus_mux_sel), .reg_bank_write(reg_bank_write), .reg_a_write(reg_a_write),
    .reg_g_write(reg_g_write), .reg_h_write(reg_h_write), .alu_op(alu_op),
    .busy(busy), .done(done), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Packs expected control outputs: {sel, bank, a, g, h, alu, done, busy, tick}
  function automatic logic [31:0] ctl(input logic [3:0] sel, input logic [7:0] bank,
                                      input logic a, input logic g, input logic h,
                                      input logic [2:0] alu, input logic dn,
                                      input logic [3:0] tk);
    return {8'h0, sel, bank, a, g, h, alu, dn, (tk != S_IDLE), tk};
  endfunction

  function automatic logic [31:0] obs_ctl();
    return {8'h0, bus_mux_sel, reg_bank_write, reg_a_write, reg_g_write, reg_h_write,
            alu_op, done, busy, tick};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [8:0] instr);
    din = instr;
    run = 1'b1;
    step();
    run = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; din = '0;
`ifdef CTRL_MUL_STALL_EN
    alu_ready = 1'b1;
`else
    alu_ready = 1'b0;
`endif
    step(); step();
    check("reset_ctl", obs_ctl(), ctl(0, 0, 0, 0, 0, 0, 0, S_IDLE));
    check("reset_ir", {23'h0, ir}, 32'h0);
    rst = 1'b0;
    step();
    check("idle_hold", obs_ctl(), ctl(0, 0, 0, 0, 0, 0, 0, S_IDLE));

    // MOV_I R3 then DISP R3
    issue(9'o730); din = 9'h1F5;
    check("movi_r3_t1", obs_ctl(), ctl(8, 8'h08, 0, 0, 0, 0, 1, S_T1));
    check("movi_r3_ir", {23'h0, ir}, {23'h0, 9'o730});
    step();
    check("movi_r3_idle", obs_ctl(), ctl(0, 0, 0, 0, 0, 0, 0, S_IDLE));
    issue(9'o030);
    check("disp_r3_t1", obs_ctl(), ctl(3, 0, 0, 0, 1, 0, 1, S_T1));
    step();
    check("disp_r3_idle", obs_ctl(), ctl(0, 0, 0, 0, 0, 0, 0, S_IDLE));

    // MOV_I R1, MOV_I R2, ADD R1,R2
    issue(9'o710); din = 9'd5;
    check("movi_r1_t1", obs_ctl(), ctl(8, 8'h02, 0, 0, 0, 0, 1, S_T1));
    step();
    issue(9'o720); din = 9'd7;
    check("movi_r2_t1", obs_ctl(), ctl(8, 8'h04, 0, 0, 0, 0, 1, S_T1));
    step();
    issue(9'o112);
    check("add_t1", obs_ctl(), ctl(1, 0, 1, 0, 0, 0, 0, S_T1));
    step();
    check("add_t2", obs_ctl(), ctl(2, 0, 0, 1, 0, 3'b000, 0, S_T2));
    step();
    check("add_t3", obs_ctl(), ctl(9, 8'h02, 0, 0, 0, 0, 1, S_T3));
    step();
    check("add_idle", obs_ctl(), ctl(0, 0, 0, 0, 0, 0, 0, S_IDLE));

    // ADD_I R1,#-3
    issue(9'o210);
    check("addi_t1", obs_ctl(), ctl(1, 0, 1, 0, 0, 0, 0, S_T1));
    din = 9'h1FD;
    step();
    check("addi_t2", obs_ctl(), ctl(8, 0, 0, 1, 0, 3'b000, 0, S_T2));
    step();
    check("addi_t3", obs_ctl(), ctl(9, 8'h02, 0, 0, 0, 0, 1, S_T3));
    step();

    // SUB R5,R6 with a stray run during T2
    issue(9'o356);
    check("sub_t1", obs_ctl(), ctl(5, 0, 1, 0, 0, 0, 0, S_T1));
    step();
    check("sub_t2", obs_ctl(), ctl(6, 0, 0, 1, 0, 3'b001, 0, S_T2));
    run = 1'b1; din = 9'o030;
    step();
    run = 1'b0;
    check("sub_t3", obs_ctl(), ctl(9, 8'h20, 0, 0, 0, 0, 1, S_T3));
    check("sub_ir_kept", {23'h0, ir}, {23'h0, 9'o356});
    step();
    check("sub_idle", obs_ctl(), ctl(0, 0, 0, 0, 0, 0, 0, S_IDLE));
    step();
    check("sub_idle2", obs_ctl(), ctl(0, 0, 0, 0, 0, 0, 0, S_IDLE));

    // SRL R0,R1 and SLL R7,R0
    issue(9'o501); step();
    check("srl_t2", obs_ctl(), ctl(1, 0, 0, 1, 0, 3'b011, 0, S_T2));
    step(); step();
    issue(9'o670); step();
    check("sll_t2", obs_ctl(), ctl(0, 0, 0, 1, 0, 3'b100, 0, S_T2));
    step();
    check("sll_t3", obs_ctl(), ctl(9, 8'h80, 0, 0, 0, 0, 1, S_T3));
    step();

    // run held high: DISP R4 back-to-back, one IDLE cycle between
    din = 9'o040; run = 1'b1;
    step();
    check("b2b_t1a", obs_ctl(), ctl(4, 0, 0, 0, 1, 0, 1, S_T1));
    step();
    check("b2b_idle", obs_ctl(), ctl(0, 0, 0, 0, 0, 0, 0, S_IDLE));
    step();
    check("b2b_t1b", obs_ctl(), ctl(4, 0, 0, 0, 1, 0, 1, S_T1));
    run = 1'b0;
    step();
    check("b2b_end", obs_ctl(), ctl(0, 0, 0, 0, 0, 0, 0, S_IDLE));

    // MUL R4,R5 with alu_ready low
    alu_ready = 1'b0;
    issue(9'o445);
    check("mul_t1", obs_ctl(), ctl(4, 0, 1, 0, 0, 0, 0, S_T1));
    step();
`ifdef CTRL_MUL_STALL_EN
    for (int i = 0; i < 3; i++) begin
      check("mul_stall", obs_ctl(), ctl(5, 0, 0, 0, 0, 3'b010, 0, S_T2));
      step();
    end
    check("mul_wait_end", obs_ctl(), ctl(5, 0, 0, 0, 0, 3'b010, 0, S_T2));
    alu_ready = 1'b1;
    #1;
    check("mul_ready_g", obs_ctl(), ctl(5, 0, 0, 1, 0, 3'b010, 0, S_T2));
`else
    check("mul_t2", obs_ctl(), ctl(5, 0, 0, 1, 0, 3'b010, 0, S_T2));
`endif
    step();
    check("mul_t3", obs_ctl(), ctl(9, 8'h10, 0, 0, 0, 0, 1, S_T3));
    step();
    check("mul_idle", obs_ctl(), ctl(0, 0, 0, 0, 0, 0, 0, S_IDLE));

    // Asynchronous reset in T2 of a MUL
`ifdef CTRL_MUL_STALL_EN
    alu_ready = 1'b1;
`endif
    issue(9'o445); step();
    check("mulr_t2", obs_ctl(), ctl(5, 0, 0, 1, 0, 3'b010, 0, S_T2));
    #2 rst = 1'b1;
    #1;
    check("mulr_rst_ctl", obs_ctl(), ctl(0, 0, 0, 0, 0, 0, 0, S_IDLE));
    check("mulr_rst_ir", {23'h0, ir}, 32'h0);
    step();
    rst = 1'b0;
    step();
    check("mulr_after", obs_ctl(), ctl(0, 0, 0, 0, 0, 0, 0, S_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
